// File: rtl/ex_div_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_pkg -- shared definitions for the EX-stage iterative divider.
//
// Contents:
//   REG_W       : data word width (register bus width)
//   CNT_W       : iteration counter width (one step per quotient bit)
//   LAST_STEP   : counter value of the final shift-subtract step
//   ZERO_WORD   : all-zeros result constant
//   ONES_WORD   : all-ones result constant (divide-by-zero quotient)
//   div_state_e : divider FSM states (free / busy / result ready)
// ---------------------------------------------------------------------------
package ex_div_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(REG_W - 1);

  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_W-1:0] ONES_WORD = '1;

  typedef enum logic [1:0] {
    DIV_FREE = 2'd0,  // idle, waiting for a request
    DIV_ON   = 2'd1,  // iterating, one quotient bit per cycle
    DIV_END  = 2'd2   // result valid for this single cycle
  } div_state_e;

endpackage : ex_div_pkg

// File: rtl/ex_div.sv
// ---------------------------------------------------------------------------
// ex_div -- multi-cycle 32-bit integer divider for the EX stage.
//
// A restoring shift-subtract divider producing one quotient bit per cycle.
// Signed operations divide operand magnitudes and fix up the signs at the
// end (quotient truncates toward zero, remainder takes the dividend's sign).
// Division by zero bypasses the iteration and returns all-ones / dividend.
//
// Ports:
//   clk        in   1  : clock, all state updates on the rising edge
//   rst        in   1  : synchronous active-high reset
//   start      in   1  : divide request, held by EX until ready
//   signed_div in   1  : 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   opv1       in  32  : dividend
//   opv2       in  32  : divisor
//   cancel     in   1  : pipeline flush, aborts any operation
//   quotient   out 32  : quotient, qualified by ready
//   remainder  out 32  : remainder, qualified by ready
//   ready      out  1  : result valid, one-cycle pulse
//   stall_req  out  1  : freeze request to pipeline control
// ---------------------------------------------------------------------------
module ex_div
  import ex_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [REG_W-1:0] opv1,
  input  logic [REG_W-1:0] opv2,
  input  logic             cancel,
  output logic [REG_W-1:0] quotient,
  output logic [REG_W-1:0] remainder,
  output logic             ready,
  output logic             stall_req
);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Two's-complement negation, modulo 2^32.
  function automatic logic [REG_W-1:0] neg_word(input logic [REG_W-1:0] v);
    return ~v + REG_W'(1);
  endfunction

  // Magnitude of v when interpreted as signed; raw value otherwise.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [REG_W-1:0] mag_word(input logic [REG_W-1:0] v,
                                                input logic             is_signed);
    return (is_signed && v[REG_W-1]) ? neg_word(v) : v;
  endfunction

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  div_state_e           state_q;
  div_state_e           state_d;
  logic [CNT_W-1:0]     count_q;
  logic [2*REG_W-1:0]   work_q;        // {partial remainder, dividend/quotient}
  logic [REG_W-1:0]     divisor_q;
  logic                 dividend_neg_q;
  logic                 divisor_neg_q;
  logic                 signed_q;

  logic                 divisor_zero;
  logic                 last_step;

  assign divisor_zero = (opv2 == ZERO_WORD);
  assign last_step    = (count_q == LAST_STEP);

  // -------------------------------------------------------------------------
  // One restoring step: shift left by one, trial-subtract the divisor from
  // the upper half and keep the difference if it did not borrow.
  // The shifted partial remainder needs 33 bits: it is below the divisor
  // before the shift, so after the shift it can exceed 2^32 - 1.
  // -------------------------------------------------------------------------
  logic [REG_W:0]       partial;
  logic [REG_W+1:0]     trial;
  logic                 no_borrow;
  logic [2*REG_W-1:0]   step_next;

  assign partial   = work_q[2*REG_W-1:REG_W-1];
  assign trial     = {1'b0, partial} - {2'b00, divisor_q};
  assign no_borrow = ~trial[REG_W+1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    step_next = {work_q[2*REG_W-2:0], 1'b0};
    if (no_borrow) begin
      step_next = {trial[REG_W-1:0], work_q[REG_W-2:0], 1'b1};
    end
  end

  // Sign correction applied to the final step's result as it is stored.
  logic [REG_W-1:0] quo_raw;
  logic [REG_W-1:0] rem_raw;
  logic [REG_W-1:0] quo_fixed;
  logic [REG_W-1:0] rem_fixed;

  assign quo_raw   = step_next[REG_W-1:0];
  assign rem_raw   = step_next[2*REG_W-1:REG_W];
  assign quo_fixed = (signed_q && (dividend_neg_q ^ divisor_neg_q))
                     ? neg_word(quo_raw) : quo_raw;
  assign rem_fixed = (signed_q && dividend_neg_q) ? neg_word(rem_raw) : rem_raw;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= DIV_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. cancel overrides everything but reset.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start) begin
          state_d = divisor_zero ? DIV_END : DIV_ON;
        end
      end
      DIV_ON: begin
        if (last_step) begin
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        // Result is presented for exactly one cycle.
        state_d = DIV_FREE;
      end
      default: begin
        state_d = DIV_FREE;
      end
    endcase
    if (cancel) begin
      state_d = DIV_FREE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers. Results are written only when an operation completes
  // and otherwise hold; ready is the sole qualifier for the outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the divider holds only a handful of flops (no memory arrays), so
    // every register is reset to give a fully defined post-reset state.
    if (rst) begin
      count_q        <= '0;
      work_q         <= '0;
      divisor_q      <= ZERO_WORD;
      dividend_neg_q <= 1'b0;
      divisor_neg_q  <= 1'b0;
      signed_q       <= 1'b0;
      quotient       <= ZERO_WORD;
      remainder      <= ZERO_WORD;
    end else if (!cancel) begin
      unique case (state_q)
        DIV_FREE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient  <= ONES_WORD;
              remainder <= opv1;
            end else begin
              work_q         <= {ZERO_WORD, mag_word(opv1, signed_div)};
              divisor_q      <= mag_word(opv2, signed_div);
              dividend_neg_q <= opv1[REG_W-1];
              divisor_neg_q  <= opv2[REG_W-1];
              signed_q       <= signed_div;
              count_q        <= '0;
            end
          end
        end
        DIV_ON: begin
          work_q  <= step_next;
          count_q <= count_q + CNT_W'(1);
          if (last_step) begin
            quotient  <= quo_fixed;
            remainder <= rem_fixed;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ready     = (state_q == DIV_END);
  assign stall_req = start & ~ready & ~cancel;

endmodule : ex_div

// File: tb/tb_ex_div.sv
// ---------------------------------------------------------------------------
// tb_ex_div -- self-checking bench for ex_div.
//
// Directed cases for the documented examples plus randomized operations,
// each checked against an arithmetic reference model (plain / and % on
// 64-bit signed or 32-bit unsigned values).
// ---------------------------------------------------------------------------
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opv1;
  logic [31:0] opv2;
  logic        cancel;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        stall_req;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ready_cyc = 0;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opv1       (opv1),
    .opv2       (opv2),
    .cancel     (cancel),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V style division semantics.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint tq;
    longint tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;          // truncates toward zero
      tr = sa % sb;          // sign follows the dividend
      q  = tq[31:0];
      r  = tr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and check latency, results and stall behaviour.
  // Entered either in IDLE or in the ready cycle of a previous operation.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input bit keep_start,
                        input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    ref_div(a, b, sgn, eq, er);
    start      = 1'b1;
    signed_div = sgn;
    opv1       = a;
    opv2       = b;
    if (ready) begin
      // The DONE->IDLE edge ignores start; acceptance happens one edge later.
      tick();
      check({tag, "_idle_gap"}, {31'd0, ready}, 32'd0);
    end
    tick();  // accepting edge
    lat = 0;
    while (!ready && lat < 40) begin
      if (lat == 3) check({tag, "_stall_busy"}, {31'd0, stall_req}, 32'd1);
      // Operands change freely while busy and must not affect the result.
      opv1       = $urandom;
      opv2       = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    last_ready_cyc = cyc;
    check({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
    if (!keep_start) start = 1'b0;
  endtask

  initial begin
    int c1;
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0;
    opv1 = '0; opv2 = '0; cancel = 1'b0;
    repeat (3) tick();
    check("rst_quo", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    tick();

    // Unsigned 100/7, then results must hold outside the ready cycle.
    do_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
    tick();
    check("hold_ready", {31'd0, ready}, 32'd0);
    check("hold_quo", quotient, 32'd14);
    check("hold_rem", remainder, 32'd2);

    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s_m7_2");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "u_m7_2");
    do_div(32'h1234, 32'd0, 1'b1, 1'b0, "s_dz");
    do_div(32'h1234, 32'd0, 1'b0, 1'b0, "u_dz");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_ovf");
    do_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "u_big");

    // cancel in IDLE beats start: no stall request, no acceptance.
    tick();
    start = 1'b1; cancel = 1'b1; opv1 = 32'd5; opv2 = 32'd0;
    #1;
    check("cancel_idle_stall", {31'd0, stall_req}, 32'd0);
    tick();
    check("cancel_idle_ready", {31'd0, ready}, 32'd0);
    start = 1'b0; cancel = 1'b0;
    tick();

    // Cancel mid-operation at counter == 10.
    start = 1'b1; signed_div = 1'b0; opv1 = 32'd1000; opv2 = 32'd3;
    tick();            // accepted, counter = 0
    repeat (10) tick();  // counter = 10
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    start  = 1'b0;
    pulses = 0;
    repeat (40) begin
      if (ready) pulses++;
      tick();
    end
    check("cancel_no_ready", 32'(pulses), 32'd0);
    do_div(32'd9, 32'd3, 1'b0, 1'b0, "after_cancel");

    // Back-to-back with start held: DONE->IDLE edge, then accept, then 32.
    tick();
    do_div(32'd50, 32'd5, 1'b0, 1'b1, "b2b_a");
    c1 = last_ready_cyc;
    do_div(32'd17, 32'd4, 1'b0, 1'b0, "b2b_b");
    check("b2b_gap", 32'(last_ready_cyc - c1), 32'd34);

    // Reset mid-BUSY: aborts with no pulse and zeroed outputs.
    tick();
    start = 1'b1; opv1 = 32'd12345; opv2 = 32'd7;
    tick();
    repeat (6) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    check("rstbusy_quo", quotient, 32'd0);
    check("rstbusy_rem", remainder, 32'd0);
    check("rstbusy_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      if (ready) pulses++;
      tick();
    end
    check("rstbusy_no_ready", 32'(pulses), 32'd0);

    // start held through reset release is accepted on the first free edge.
    rst = 1'b1; start = 1'b1; opv1 = 32'd77; opv2 = 32'd10;
    repeat (2) tick();
    check("rst_start_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    do_div(32'd77, 32'd10, 1'b0, 1'b0, "rst_release");

    // Randomized operations, including zero divisors and overflow corners.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = b >> $urandom_range(1, 31);
        3: a = a >> $urandom_range(1, 31);
        default: ;
      endcase
      do_div(a, b, s, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    start = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ex_div
